spi_receiver: RTL
=================

# spi_receiver

Receiving end of the team's SPI-style serial link: deserializes MSB-first words framed by active-low `cs` on `mosi` and buffers them in a small show-ahead FIFO for downstream logic. It runs on the same `sclk` as the transmitter. The transmitter updates `mosi`/`cs` on the falling edge; this block samples on the rising edge. It also detects malformed frames (short or over-long) and FIFO overflow.

## Interface
- `WORD_W`, 8, bits per frame; 2..16.
- `FIFO_DEPTH`, 4, FIFO entries; power of two, ≥2.
- `sclk`  in  1  single clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `mosi`  in  1  serial data, MSB first.
- `cs`  in  1  frame enable, active low.
- `rd_en`  in  1  pop request from the consumer.
- `data_out`  out  WORD_W  head of FIFO; valid while `empty`=0.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- `frame_error`  out  1  one-cycle pulse on a malformed frame.
- `overflow`  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- Reset values: `data_out`=0, `empty`=1, `full`=0, `count`=0, `frame_error`=0, `overflow`=0. The shift register and bit counter clear, and the FSM enters SYNC.
- FSM states:
  - **SYNC**: ignores all input. On a sample with `cs`=1 → IDLE. This prevents a mid-frame reset from misaligning words.
  - **IDLE**: on a sample with `cs`=0, shifts `mosi` into bit 0, sets `bit_cnt`=1, and goes to SHIFT. If `WORD_W` is 1 it would complete immediately, but `WORD_W`≥2 by definition.
  - **SHIFT**:
    - `cs`=0: `shift <= {shift[WORD_W-2:0], mosi}`, `bit_cnt++`.
    - Sampling the WORD_W-th bit: push `{shift[WORD_W-2:0], mosi}` into the FIFO on that same edge, then go to HOLD.
    - `cs`=1 before completion: pulse `frame_error`, discard the partial word, go to IDLE.
  - **HOLD**:
    - `cs`=1 → IDLE.
    - `cs`=0 (extra bits): pulse `frame_error` once, go to FLUSH.
  - **FLUSH**: ignore input until `cs`=1 → IDLE. No further error pulses.
- The push in the over-long case has already occurred; a word that completed correctly is never retracted.
- FIFO behaviour:
  - Show-ahead: `data_out` always reflects the oldest entry.
  - `rd_en` with `empty`=1 is ignored and does not change `count`.
  - Push when `full` and no pop: the word is dropped and `overflow` pulses for one cycle. FIFO contents are unchanged.
  - Push and pop on the same edge: both take effect, including when full, and `count` is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - `count` is exact. `full` = (`count`==FIFO_DEPTH). `empty` = (`count`==0).
- Reset during any state discards the partial word and all FIFO contents.

## Timing
- Bit sampling: rising `sclk` edge while `cs`=0. The first sample after `cs` falls is the MSB.
- Latency: a word is visible on `data_out` with `empty`=0 immediately after the edge that samples its LSB (0 extra cycles).
- Frame gap: the transmitter's inter-word pause is ≥1 cycle with `cs`=1. HOLD→IDLE takes one cycle, so a gap of exactly one high sample is sufficient.
- `frame_error` and `overflow` are registered, high for exactly one cycle, and can coincide.
- Pop: `rd_en` is sampled on a rising edge. The next entry, or `empty`=1, appears after that edge.

## Structure
- Shared package `spi_pkg`:
  - `rx_state_t` enum (SYNC, IDLE, SHIFT, HOLD, FLUSH).
  - Default word width constant, shared with the transmitter.
- Sub-module `spi_rx_fifo`, parameterized by `WORD_W`/`FIFO_DEPTH`:
  - Inputs: push, push data, pop.
  - Outputs: `data_out`, `empty`, `full`, `count`, `overflow`.
- Top level holds the FSM, shift register and bit counter.

## Test plan
- Reset, hold `cs`=1 for 3 cycles, send 0xA5 MSB-first in one frame → after the 8th rising edge `data_out`=0xA5, `empty`=0, `count`=1. Then `rd_en` one cycle → `empty`=1.
- Send 0x01, 0x80, 0xFF, 0x3C back-to-back with 1-cycle `cs`-high gaps and no reads → `full`=1, `count`=4. A fifth word 0x77 → `overflow` pulses once and the FIFO is unchanged. Pops return 0x01, 0x80, 0xFF, 0x3C in order.
- Frame of 5 bits, then `cs`=1 → `frame_error` pulses once and `count` stays 0. The next full 0x5A frame is received correctly.
- Frame of 10 bits (0xC3 then two extra bits) → 0xC3 pushed, `frame_error` pulses once on the 9th sample, nothing further until `cs` rises.
- FIFO full, last word completes on the same edge as `rd_en` → no `overflow`, `count` stays 4, and the head advances.
- Assert `reset` after 4 bits of a frame while `cs` stays low for 4 more bits → no push and no `frame_error`. After `cs` rises, 0x96 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI link definitions: receiver FSM states and link-wide defaults.
package spi_pkg;

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StShift,
        StHold,
        StFlush
    } rx_state_t;

    localparam int unsigned SPI_WORD_W     = 8;
    localparam int unsigned SPI_FIFO_DEPTH = 4;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead receive FIFO with exact occupancy count and registered overflow pulse.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W     = SPI_WORD_W,
    parameter int unsigned FIFO_DEPTH = SPI_FIFO_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic [WORD_W-1:0]             i_push_data,
    input  logic                          i_pop,
    output logic [WORD_W-1:0]             o_data_out,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_push && w_full && !w_pop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_data_out = r_mem[r_rd_ptr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/spi_receiver.sv
// SPI receive path: cs-framed MSB-first deserializer with frame checking,
// feeding a show-ahead FIFO. Completed words are pushed on their LSB edge.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W     = SPI_WORD_W,
    parameter int unsigned FIFO_DEPTH = SPI_FIFO_DEPTH
) (
    input  logic                          i_sclk,
    input  logic                          i_reset,
    input  logic                          i_mosi,
    input  logic                          i_cs,
    input  logic                          i_rd_en,
    output logic [WORD_W-1:0]             o_data_out,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_frame_error,
    output logic                          o_overflow
);

    localparam int unsigned BCW = $clog2(WORD_W + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

    rx_state_t         r_state;
    logic [WORD_W-2:0] r_shift;
    logic [BCW-1:0]    r_bit_cnt;
    logic              r_frame_error;

    logic [WORD_W-1:0] w_word;
    logic              w_push;

    assign w_word = {r_shift, i_mosi};
    assign w_push = (r_state == StShift) && !i_cs && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            r_state       <= StSync;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            case (r_state)
                // Wait for a cs-high sample so a mid-frame reset cannot misalign words.
                StSync: begin
                    if (i_cs) r_state <= StIdle;
                end
                StIdle: begin
                    if (!i_cs) begin
                        r_shift   <= (WORD_W - 1)'(i_mosi);
                        r_bit_cnt <= BCW'(1);
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    if (i_cs) begin
                        r_frame_error <= 1'b1;
                        r_bit_cnt     <= '0;
                        r_state       <= StIdle;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        r_shift   <= w_word[WORD_W-2:0];
                        r_bit_cnt <= '0;
                        r_state   <= StHold;
                    end else begin
                        r_shift   <= w_word[WORD_W-2:0];
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                end
                StHold: begin
                    if (i_cs) begin
                        r_state <= StIdle;
                    end else begin
                        r_frame_error <= 1'b1;
                        r_state       <= StFlush;
                    end
                end
                StFlush: begin
                    if (i_cs) r_state <= StIdle;
                end
                default: r_state <= StSync;
            endcase
        end
    end

    spi_rx_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_sclk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (w_word),
        .i_pop       (i_rd_en),
        .o_data_out  (o_data_out),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_count     (o_count),
        .o_overflow  (o_overflow)
    );

    assign o_frame_error = r_frame_error;

endmodule
